shift_mix_columns: RTL and testbench

- Round stage directly downstream of the registered SubBytes output.
- Applies ShiftRows, then MixColumns, to a 128-bit AES state.
- Processes one column per cycle through a single shared column multiplier, behind a valid/ready handshake.
- MixColumns is bypassed on the final round, so its output feeds AddRoundKey for every round.

---
 rtl/shift_mix_columns_pkg.sv | 37 +++
 rtl/shift_mix_columns_mix_single_column.sv | 33 +++
 rtl/shift_mix_columns.sv | 79 +++++++
 tb/tb_shift_mix_columns.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_mix_columns_pkg.sv
// Shared AES round-stage definitions: FSM encoding, reduction polynomial, byte/column index helpers.
// Also holds the ShiftRows permutation, which is pure wiring and costs no cycle.
package shift_mix_columns_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] AES_REDUCE_POLY = 8'h1B;
  localparam int         AES_ROWS        = 4;
  localparam int         AES_COLS        = 4;

  // Byte k of the state lives at bits [127-8k -: 8]; this returns its LSB.
  function automatic int byte_lsb(input int k);
    return 120 - 8 * k;
  endfunction

  // Column c occupies bytes 4c..4c+3, i.e. bits [127-32c -: 32].
  function automatic logic [6:0] col_lsb(input logic [1:0] c);
    return {2'd3 - c, 5'd0};
  endfunction

  // s'[r][c] = s[r][(c+r) mod 4], with s[r][c] = byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < AES_ROWS; r++) begin
      for (int c = 0; c < AES_COLS; c++) begin
        t[byte_lsb(r + 4 * c) +: 8] = s[byte_lsb(r + 4 * ((c + r) % 4)) +: 8];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/shift_mix_columns_mix_single_column.sv
// MixColumns on one 32-bit column (a0 in bits 31:24); combinational, no handshake.
// Kept standalone so inverse-cipher and key-schedule logic can reuse it.
module mix_single_column
  import shift_mix_columns_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_REDUCE_POLY : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3x is expanded as xtime(x) ^ x.
  assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/shift_mix_columns.sv
// ShiftRows then MixColumns (bypassed on last round), one column per cycle; o_Valid 4 cycles after accept.
// Not ready while computing or holding a result; holds o_Data/o_Valid until i_Ready.
module shift_mix_columns
  import shift_mix_columns_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  input  logic         i_Last_Round,
  output logic [127:0] o_Data,
  output logic         o_Valid,
  input  logic         i_Ready
);

  state_t       state;
  logic [1:0]   col;
  logic         last_q;
  logic [127:0] work;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  assign col_in = work[col_lsb(col) +: 32];
  assign o_Data = work;

  mix_single_column u_mix (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      col     <= 2'd0;
      last_q  <= 1'b0;
      work    <= '0;
      o_Valid <= 1'b0;
      o_Ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Valid) begin
            work    <= shift_rows(i_Data);
            last_q  <= i_Last_Round;
            col     <= 2'd0;
            o_Ready <= 1'b0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!last_q) begin
            work[col_lsb(col) +: 32] <= col_out;
          end
          col <= col + 2'd1;
          if (col == 2'd3) begin
            o_Valid <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_Ready) begin
            o_Valid <= 1'b0;
            o_Ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to an idle, empty stage.
          col     <= 2'd0;
          o_Valid <= 1'b0;
          o_Ready <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mix_columns.sv
// Directed bench for shift_mix_columns: FIPS-197 vectors, bypass, backpressure, reset abort, streaming.
module tb_shift_mix_columns;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Data;
  logic         i_Last_Round;
  logic [127:0] o_Data;
  logic         o_Valid;
  logic         i_Ready;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] APPB_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] APPB_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] APPB_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  // db,13,53,45 placed so ShiftRows gathers them into column 0.
  localparam logic [127:0] COL_IN   = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [127:0] COL_EXP  = 128'h8e4da1bc_00000000_00000000_00000000;

  always #5 clk = ~clk;

  shift_mix_columns dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_Valid      (i_Valid),
    .o_Ready      (o_Ready),
    .i_Data       (i_Data),
    .i_Last_Round (i_Last_Round),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .i_Ready      (i_Ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input logic last);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k % 4][k / 4] = din[127 - 8 * k -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
        t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = t[k % 4][k / 4];
    return res;
  endfunction

  // Accept one state, then check the exact 4-cycle latency and the result.
  task automatic run_one(input string tag, input logic [127:0] d, input logic lst,
                         input logic [127:0] exp);
    chk({tag, "_rdy_before"}, 128'(o_Ready), 128'd1);
    i_Valid      = 1'b1;
    i_Data       = d;
    i_Last_Round = lst;
    step();
    i_Valid      = 1'b0;
    i_Data       = ~d;
    i_Last_Round = ~lst;
    chk({tag, "_rdy_busy"}, 128'(o_Ready), 128'd0);
    step();
    step();
    step();
    chk({tag, "_vld_early"}, 128'(o_Valid), 128'd0);
    step();
    chk({tag, "_vld"}, 128'(o_Valid), 128'd1);
    chk({tag, "_dat"}, o_Data, exp);
  endtask

  task automatic release_out(input string tag);
    i_Ready = 1'b1;
    step();
    i_Ready = 1'b0;
    chk({tag, "_vld_drop"}, 128'(o_Valid), 128'd0);
    chk({tag, "_rdy_back"}, 128'(o_Ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [127:0] held;
  logic [127:0] din  [3];
  logic [127:0] expq [3];
  int           out_cyc [3];
  int           in_idx;
  int           out_idx;
  logic         acc;

  initial begin
    rst_n        = 1'b0;
    i_Valid      = 1'b0;
    i_Data       = '0;
    i_Last_Round = 1'b0;
    i_Ready      = 1'b0;
    step();
    step();
    chk("reset_vld", 128'(o_Valid), 128'd0);
    chk("reset_dat", o_Data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_rdy", 128'(o_Ready), 128'd1);

    run_one("appb_r1", APPB_IN, 1'b0, APPB_MIX);
    release_out("appb_r1");

    run_one("last_round", APPB_IN, 1'b1, APPB_SR);
    release_out("last_round");

    run_one("single_col", COL_IN, 1'b0, COL_EXP);
    release_out("single_col");

    // Backpressure: result must hold while a competing i_Valid is presented.
    run_one("bp", APPB_IN, 1'b0, APPB_MIX);
    held    = o_Data;
    i_Valid = 1'b1;
    i_Data  = COL_IN;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_vld", 128'(o_Valid), 128'd1);
      chk("bp_hold_dat", o_Data, held);
      chk("bp_hold_rdy", 128'(o_Ready), 128'd0);
    end
    i_Valid = 1'b0;
    release_out("bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_no_capture_vld", 128'(o_Valid), 128'd0);
      chk("bp_no_capture_dat", o_Data, APPB_MIX);
    end

    // Reset during the second CALC cycle discards the partial state.
    i_Valid = 1'b1;
    i_Data  = APPB_IN;
    step();
    i_Valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 128'(o_Valid), 128'd0);
    chk("abort_dat", o_Data, 128'h0);
    chk("abort_rdy", 128'(o_Ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_one("after_abort", APPB_IN, 1'b0, APPB_MIX);
    release_out("after_abort");

    // Streaming with i_Valid held high and i_Ready tied high.
    for (int i = 0; i < 3; i++) begin
      din[i]     = {$urandom, $urandom, $urandom, $urandom};
      expq[i]    = model(din[i], 1'b0);
      out_cyc[i] = 0;
    end
    in_idx       = 0;
    out_idx      = 0;
    i_Ready      = 1'b1;
    i_Valid      = 1'b1;
    i_Last_Round = 1'b0;
    i_Data       = din[0];
    for (int cyc = 0; cyc < 60 && out_idx < 3; cyc++) begin
      acc = o_Ready && i_Valid;
      step();
      if (acc) begin
        in_idx++;
        if (in_idx < 3) i_Data = din[in_idx];
        else            i_Valid = 1'b0;
      end
      if (o_Valid) begin
        chk("stream_dat", o_Data, expq[out_idx]);
        out_cyc[out_idx] = cyc;
        out_idx++;
      end
    end
    i_Valid = 1'b0;
    chk("stream_count", 128'(out_idx), 128'd3);
    chk("stream_gap01", 128'(out_cyc[1] - out_cyc[0]), 128'd6);
    chk("stream_gap12", 128'(out_cyc[2] - out_cyc[1]), 128'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
